// File: rtl/count_history_display.sv
// Display stage for the ROM-based counter: keeps a four-deep history of distinct
// count values and scans it onto a multiplexed, active-low 4-digit 7-seg display.
module count_history_display #(
  parameter int DIGIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] count,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       new_val,
  output logic [7:0] changes
);

  localparam int DIV_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t           state, state_next;
  logic [2:0]       hist [4];
  logic [3:0]       valid;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       digit_sel;
  logic             do_prime, do_shift;
  logic [6:0]       seg_next;
  logic [3:0]       an_next;
  logic             dp_next;

  function automatic logic [6:0] seg_decode(input logic [2:0] v);
    case (v)
      3'd0:    return 7'h40;
      3'd1:    return 7'h79;
      3'd2:    return 7'h24;
      3'd3:    return 7'h30;
      3'd4:    return 7'h19;
      3'd5:    return 7'h12;
      3'd6:    return 7'h02;
      default: return 7'h78;
    endcase
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_next = state;
    do_prime   = 1'b0;
    do_shift   = 1'b0;
    case (state)
      PRIME: begin
        do_prime   = 1'b1;
        state_next = RUN;
      end
      RUN:     do_shift = (count != hist[0]);
      default: state_next = PRIME;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= PRIME;
    else       state <= state_next;
  end

  // NOTE: the history is only four 3-bit registers, so it is reset like any other state rather than left uninitialised.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hist[i] <= 3'd0;
      valid   <= 4'b0000;
      new_val <= 1'b0;
      changes <= 8'd0;
    end else begin
      new_val <= do_prime | do_shift;
      if (do_prime) begin
        hist[0]  <= count;
        valid[0] <= 1'b1;
      end else if (do_shift) begin
        hist[3] <= hist[2];
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= count;
        valid   <= {valid[2:0], 1'b1};
        changes <= changes + 8'd1;
      end
    end
  end

  // Scan divider: digit_sel advances once every DIGIT_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      digit_sel <= 2'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    an_next  = 4'hF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (valid[digit_sel]) begin
      an_next  = ~(4'b0001 << digit_sel);
      seg_next = seg_decode(hist[digit_sel]);
      dp_next  = (digit_sel != 2'd0);
    end
  end

  // Registered pins keep the display free of decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'h7F;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_count_history_display.sv
// Scoreboard bench for count_history_display: a queue-based history model predicts
// every cycle's pins for two scan rates (DIGIT_CYCLES = 4 and 1).
module tb_count_history_display;

  logic       clk;
  logic       reset;
  logic [2:0] count;

  logic [6:0] seg4, seg1;
  logic       dp4, dp1;
  logic [3:0] an4, an1;
  logic       nv4, nv1;
  logic [7:0] chg4, chg1;

  count_history_display #(.DIGIT_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .count(count),
    .seg(seg4), .dp(dp4), .an(an4), .new_val(nv4), .changes(chg4)
  );

  count_history_display #(.DIGIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .count(count),
    .seg(seg1), .dp(dp1), .an(an1), .new_val(nv1), .changes(chg1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       nv;
    logic [7:0] chg;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb4[$];
  exp_t sb1[$];

  int compared = 0;
  int mismatched = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history is a newest-first queue of distinct values, the
  // lit digit is (edges since reset / DIGIT_CYCLES) mod 4.
  logic [6:0] seg_tbl [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  logic [2:0] mq[$];
  bit         primed = 0;
  int         t = 0;
  int         mchg = 0;

  function automatic exp_t display(input int dc);
    exp_t e;
    int   sel;
    sel = (t / dc) % 4;
    e   = '0;
    if (sel < mq.size()) begin
      e.an  = ~(4'b0001 << sel);
      e.seg = seg_tbl[mq[sel]];
      e.dp  = (sel != 0);
    end else begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e4, e1;
    logic nv;
    if (reset) begin
      mq.delete();
      primed = 0;
      t      = 0;
      mchg   = 0;
      e4     = '{nv: 1'b0, chg: 8'd0, an: 4'hF, seg: 7'h7F, dp: 1'b1};
      e1     = e4;
    end else begin
      e4 = display(4);
      e1 = display(1);
      t++;
      nv = 1'b0;
      if (!primed) begin
        mq.push_front(count);
        primed = 1;
        nv     = 1'b1;
      end else if (count != mq[0]) begin
        mq.push_front(count);
        if (mq.size() > 4) void'(mq.pop_back());
        mchg = (mchg + 1) % 256;
        nv   = 1'b1;
      end
      e4.nv  = nv;
      e4.chg = mchg[7:0];
      e1.nv  = nv;
      e1.chg = mchg[7:0];
    end
    sb4.push_back(e4);
    sb1.push_back(e1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      check("dc4_new_val", nv4, e.nv);
      check("dc4_changes", chg4, e.chg);
      check("dc4_an", an4, e.an);
      check("dc4_seg", seg4, e.seg);
      check("dc4_dp", dp4, e.dp);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      check("dc1_new_val", nv1, e.nv);
      check("dc1_changes", chg1, e.chg);
      check("dc1_an", an1, e.an);
      check("dc1_seg", seg1, e.seg);
      check("dc1_dp", dp1, e.dp);
    end
  end

  task automatic hold(input logic [2:0] v, input int n);
    count = v;
    repeat (n) begin
      @(negedge clk);
      if (nv4) pulses++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] seq [7] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd0};
    bit found;

    reset = 1'b1;
    count = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_an", an4, 4'hF);
    check("reset_seg", seg4, 7'h7F);
    reset = 1'b0;
    @(negedge clk);
    check("prime_pulse", nv4, 1'b1);
    check("prime_changes", chg4, 8'd0);

    pulses = 0;
    foreach (seq[i]) hold(seq[i], 10);
    check("seq_pulses", pulses, 6);
    check("seq_changes", chg4, 8'd6);

    pulses = 0;
    hold(3'd1, 1);
    hold(3'd2, 1);
    hold(3'd3, 1);
    hold(3'd4, 1);
    hold(3'd4, 3);
    check("b2b_pulses", pulses, 4);
    check("b2b_changes", chg4, 8'd10);

    hold(3'd5, 5);
    pulses = 0;
    hold(3'd5, 50);
    check("hold_pulses", pulses, 0);
    check("hold_changes", chg4, 8'd11);

    for (int i = 0; i < 256; i++) hold((i % 2) ? 3'd6 : 3'd3, 1);
    hold(3'd6, 4);
    check("wrap_changes", chg4, 8'd11);

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an4 == 4'b1011) found = 1;
    end
    check("wait_digit2", found, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_an", an4, 4'hF);
    check("midreset_changes", chg4, 8'd0);
    @(negedge clk);
    check("reprime_pulse", nv4, 1'b1);
    hold(3'd6, 10);

    repeat (400) begin
      reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0) count = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    reset = 1'b0;
    hold(count, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/count_history_display.md
# count_history_display

Downstream display stage for the ROM-based Mealy counter. It watches the 3-bit `count` it produces and keeps a four-entry history of distinct values, newest first. It drives a multiplexed, active-low 4-digit seven-segment display, with the newest value on digit 0 and older values on digits 1-3. It also emits a change strobe and a wrap-around change counter for the bench and the LEDs.

## Interface
- `DIGIT_CYCLES`, default 100000: clock cycles each digit stays lit before the scan advances; legal range ≥1.
- `clk`  input  1: single system clock, rising edge.
- `reset`  input  1: synchronous, active-high; sampled on `clk` rising edge.
- `count`  input  3: counter output, synchronous to `clk`; may change every cycle.
- `seg`  output  7: segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- `dp`  output  1: decimal point, active-low.
- `an`  output  4: digit anodes, active-low; bit i selects digit i.
- `new_val`  output  1: one-cycle pulse when a value is loaded into history slot 0.
- `changes`  output  8: number of history shifts since reset, wraps 255→0.

## Operation
- Reset state (applies at the first edge with `reset`=1, so also mid-operation):
  - history `hist[0..3]`=0, `valid`=4'b0000, `prime`=1;
  - `div_cnt`=0, `digit_sel`=0, `changes`=0, `new_val`=0;
  - `seg`=7'h7F, `an`=4'hF, `dp`=1.
- Priming: on the first edge with `reset`=0 and `prime`=1:
  - `hist[0]`←`count`, `valid[0]`←1, `prime`←0, `new_val`←1;
  - `changes` is unchanged.
- Change detection (edges with `prime`=0), when `count` ≠ `hist[0]`:
  - shift `hist[3]`←`hist[2]`, `hist[2]`←`hist[1]`, `hist[1]`←`hist[0]`, `hist[0]`←`count`;
  - `valid`←{`valid[2:0]`,1'b1};
  - `new_val`←1 and `changes`←`changes`+1 (mod 256).
  - If `count` = `hist[0]`, nothing shifts and `new_val`←0.
- Back-to-back changes on consecutive cycles each produce a shift and a pulse; no value is dropped.
- Scan counter:
  - `div_cnt` counts 0..`DIGIT_CYCLES`-1.
  - On the edge where `div_cnt`=`DIGIT_CYCLES`-1, `div_cnt`←0 and `digit_sel`←`digit_sel`+1 (mod 4, 3→0).
  - With `DIGIT_CYCLES`=1, `digit_sel` advances every cycle.
- Output register, updated every edge from the current `digit_sel`, `hist` and `valid`:
  - `an` = active-low one-hot of `digit_sel` if `valid[digit_sel]`, else 4'hF (unfilled digits are blank).
  - `seg` = decode of `hist[digit_sel]` if valid, else 7'h7F.
  - Decode table: 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78.
  - `dp` = 0 only when `digit_sel`=0 and `valid[0]`=1 (marks the newest value), else 1.
- No other states exist. The history FSM has two states, PRIME and RUN; reset forces PRIME, and the first non-reset edge moves to RUN.

## Timing
- `count` changes after edge k.
- Edge k+1: history updates; `new_val` is high from k+1 to k+2.
- Edge k+2: `seg`/`an` reflect the new `hist[0]` if `digit_sel`=0.
- Display latency from history update to pins is exactly 1 cycle. The scan change from `digit_sel` to pins is also 1 cycle.
- Reset asserted for one edge clears all state at that edge. Priming occurs on the first following edge, so `new_val` pulses 1 cycle after reset release.
- `changes` and `new_val` are registered, with no combinational path from `count`.

## Test plan
- **Reset/prime:** hold `reset` 3 cycles with `count`=0, then release.
  - During reset: `an`=4'hF, `seg`=7'h7F, `dp`=1.
  - 1 cycle after release: `new_val`=1, `changes`=0.
  - With `DIGIT_CYCLES`=4: digit 0 shows 7'h40 with `dp`=0; digits 1-3 blank.
- **Counter sequence:** drive `count` 0,1,3,5,7,2,0, each held 10 cycles.
  - `changes`=6 at the end, 6 `new_val` pulses after priming.
  - Final history, digits 0-3 = 0,2,7,5; `seg` codes 7'h40, 7'h24, 7'h78, 7'h12.
- **Back-to-back:** change `count` every cycle 1,2,3,4.
  - 4 consecutive `new_val` pulses; `hist`={4,3,2,1}; `changes` +4.
- **Hold/no-change:** keep `count`=5 for 50 cycles after loading.
  - No `new_val`, `changes` constant.
  - Scan period per digit = `DIGIT_CYCLES` cycles; `an` rotates 1110→1101→1011→0111→1110 when all valid.
- **Wrap:** force 256 alternating changes between 3 and 6.
  - `changes` wraps to 0; `hist` stays consistent (6,3,6,3).
- **Reset mid-operation:** assert `reset` one cycle while digit 2 is lit.
  - Next cycle: `an`=4'hF, `changes`=0, `digit_sel`=0.
  - Priming repeats with the current `count`.
